// File: rtl/program_loader_if.sv
// -----------------------------------------------------------------------------
// program_loader_if
//   Groups the loader's byte-stream and program-memory signals into one bundle.
//   The byte stream arrives from the UART receiver (valid/data in, ready out)
//   and the program-memory write port leaves the loader (we/addr/wdata out).
//
//   Signals:
//     rx_valid  byte available from the UART receiver
//     rx_data   received byte
//     rx_ready  loader accepts the byte this cycle
//     pm_we     program-memory write strobe
//     pm_addr   program-memory write address (ADDR_W bits)
//     pm_wdata  instruction word {opcode[4:0], operand[10:0]}
//
//   Modports:
//     master  environment side: drives the byte stream, observes the memory port
//     slave   loader side: consumes the byte stream, drives the memory port
// -----------------------------------------------------------------------------
interface program_loader_if #(
  parameter int ADDR_W = 11
);
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              pm_we;
  logic [ADDR_W-1:0] pm_addr;
  logic [15:0]       pm_wdata;

  modport master (
    output rx_valid,
    output rx_data,
    input  rx_ready,
    input  pm_we,
    input  pm_addr,
    input  pm_wdata
  );

  modport slave (
    input  rx_valid,
    input  rx_data,
    output rx_ready,
    output pm_we,
    output pm_addr,
    output pm_wdata
  );
endinterface

// File: rtl/program_loader.sv
// -----------------------------------------------------------------------------
// program_loader
//   Loads a program into instruction memory from a UART byte stream. Each
//   instruction arrives as two bytes: the high byte carries opcode[4:0] and
//   operand[10:8], the low byte carries operand[7:0]. Every assembled word is
//   written to consecutive addresses starting at 0. The session ends normally
//   on HLT (opcode 0), or with an error on an unsupported opcode (> 7) or when
//   a non-HLT word lands on the last memory address. The CPU is held while a
//   session is in progress.
//
//   Ports:
//     i_clk          clock, all state updates on the rising edge
//     i_rst_n        asynchronous active-low reset
//     i_start        one-cycle request to begin a load session
//     bus            byte stream in / program-memory write port out
//     o_cpu_hold     stalls the CPU while loading
//     o_busy         session in progress
//     o_done         session ended on HLT
//     o_err          2'b00 none, 2'b01 illegal opcode, 2'b10 memory overflow
//     o_instr_count  words written in the current session
// -----------------------------------------------------------------------------
module program_loader #(
  parameter int ADDR_W = 11
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  program_loader_if.slave   bus,
  output logic              o_cpu_hold,
  output logic              o_busy,
  output logic              o_done,
  output logic [1:0]        o_err,
  output logic [ADDR_W:0]   o_instr_count
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HI    = 3'd1,
    S_LO    = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [4:0]        OPC_HLT   = 5'd0;
  localparam logic [4:0]        OPC_MAX   = 5'd7;

  state_t            r_state;
  logic [4:0]        r_opcode;
  logic [2:0]        r_op_hi;
  logic              r_rx_ready;
  logic              r_pm_we;
  logic [ADDR_W-1:0] r_pm_addr;
  logic [15:0]       r_pm_wdata;
  logic              r_busy;
  logic              r_done;
  logic [1:0]        r_err;
  logic [ADDR_W:0]   r_count;

  state_t            w_state_nxt;
  logic [4:0]        w_opcode_nxt;
  logic [2:0]        w_op_hi_nxt;
  logic              w_rx_ready_nxt;
  logic              w_pm_we_nxt;
  logic [ADDR_W-1:0] w_pm_addr_nxt;
  logic [15:0]       w_pm_wdata_nxt;
  logic              w_busy_nxt;
  logic              w_done_nxt;
  logic [1:0]        w_err_nxt;
  logic [ADDR_W:0]   w_count_nxt;
  logic              w_xfer;

  // rx_ready is a registered copy of "state is HI or LO", so it can gate the
  // handshake directly.
  assign w_xfer = bus.rx_valid & r_rx_ready;

  // Next-state and next-output logic; outputs are decoded from the next state
  // so that every output comes straight from a flop.
  always_comb begin
    w_state_nxt    = r_state;
    w_opcode_nxt   = r_opcode;
    w_op_hi_nxt    = r_op_hi;
    w_pm_addr_nxt  = r_pm_addr;
    w_pm_wdata_nxt = r_pm_wdata;
    w_done_nxt     = r_done;
    w_err_nxt      = r_err;
    w_count_nxt    = r_count;

    case (r_state)
      S_IDLE, S_DONE, S_ERR: begin
        if (i_start) begin
          w_state_nxt   = S_HI;
          w_pm_addr_nxt = {ADDR_W{1'b0}};
          w_count_nxt   = {(ADDR_W+1){1'b0}};
          w_done_nxt    = 1'b0;
          w_err_nxt     = 2'b00;
        end else begin
          w_state_nxt = r_state;
        end
      end

      S_HI: begin
        if (w_xfer) begin
          if (bus.rx_data[7:3] > OPC_MAX) begin
            w_state_nxt = S_ERR;
            w_err_nxt   = 2'b01;
          end else begin
            w_opcode_nxt = bus.rx_data[7:3];
            w_op_hi_nxt  = bus.rx_data[2:0];
            w_state_nxt  = S_LO;
          end
        end else begin
          w_state_nxt = S_HI;
        end
      end

      S_LO: begin
        if (w_xfer) begin
          // pm_wdata only changes here, so it keeps the last written word
          // everywhere outside the following WRITE cycle.
          w_pm_wdata_nxt = {r_opcode, r_op_hi, bus.rx_data};
          w_state_nxt    = S_WRITE;
        end else begin
          w_state_nxt = S_LO;
        end
      end

      S_WRITE: begin
        w_count_nxt = r_count + CNT_ONE;
        if (r_opcode == OPC_HLT) begin
          w_state_nxt = S_DONE;
          w_done_nxt  = 1'b1;
        end else if (r_pm_addr == ADDR_LAST) begin
          // The address never wraps: the word at the last address is already
          // written, the session stops with an overflow error.
          w_state_nxt = S_ERR;
          w_err_nxt   = 2'b10;
        end else begin
          w_pm_addr_nxt = r_pm_addr + ADDR_ONE;
          w_state_nxt   = S_HI;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    w_rx_ready_nxt = (w_state_nxt == S_HI) || (w_state_nxt == S_LO);
    w_pm_we_nxt    = (w_state_nxt == S_WRITE);
    w_busy_nxt     = w_rx_ready_nxt || w_pm_we_nxt;
  end

  // State and output registers; reset clears everything immediately.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_opcode   <= 5'd0;
      r_op_hi    <= 3'd0;
      r_rx_ready <= 1'b0;
      r_pm_we    <= 1'b0;
      r_pm_addr  <= {ADDR_W{1'b0}};
      r_pm_wdata <= 16'd0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 2'b00;
      r_count    <= {(ADDR_W+1){1'b0}};
    end else begin
      r_state    <= w_state_nxt;
      r_opcode   <= w_opcode_nxt;
      r_op_hi    <= w_op_hi_nxt;
      r_rx_ready <= w_rx_ready_nxt;
      r_pm_we    <= w_pm_we_nxt;
      r_pm_addr  <= w_pm_addr_nxt;
      r_pm_wdata <= w_pm_wdata_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      r_err      <= w_err_nxt;
      r_count    <= w_count_nxt;
    end
  end

  assign bus.rx_ready  = r_rx_ready;
  assign bus.pm_we     = r_pm_we;
  assign bus.pm_addr   = r_pm_addr;
  assign bus.pm_wdata  = r_pm_wdata;
  assign o_busy        = r_busy;
  assign o_cpu_hold    = r_busy;
  assign o_done        = r_done;
  assign o_err         = r_err;
  assign o_instr_count = r_count;

endmodule

// File: tb/tb_program_loader.sv
// -----------------------------------------------------------------------------
// tb_program_loader
//   Self-checking bench for program_loader. Two instances share the clock and
//   reset: one with the default 11-bit address, one with a 2-bit address for
//   the overflow cases. A select bit routes stimulus to one instance and
//   muxes its outputs back. Expected writes and end-of-session status come
//   from a byte-stream reference model.
// -----------------------------------------------------------------------------
module tb_program_loader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tb_start;
  logic       tb_valid;
  logic       tb_sel;
  logic [7:0] tb_data;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  program_loader_if #(.ADDR_W(11)) ifa ();
  program_loader_if #(.ADDR_W(2))  ifb ();

  logic        a_hold, a_busy, a_done, b_hold, b_busy, b_done;
  logic [1:0]  a_err, b_err;
  logic [11:0] a_count;
  logic [2:0]  b_count;
  logic        a_start, b_start;

  assign a_start      = tb_start & ~tb_sel;
  assign b_start      = tb_start &  tb_sel;
  assign ifa.rx_valid = tb_valid & ~tb_sel;
  assign ifb.rx_valid = tb_valid &  tb_sel;
  assign ifa.rx_data  = tb_data;
  assign ifb.rx_data  = tb_data;

  program_loader #(.ADDR_W(11)) u_dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(a_start), .bus(ifa),
    .o_cpu_hold(a_hold), .o_busy(a_busy), .o_done(a_done),
    .o_err(a_err), .o_instr_count(a_count)
  );

  program_loader #(.ADDR_W(2)) u_dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(b_start), .bus(ifb),
    .o_cpu_hold(b_hold), .o_busy(b_busy), .o_done(b_done),
    .o_err(b_err), .o_instr_count(b_count)
  );

  // Observed outputs of the selected instance
  logic        obs_ready, obs_we, obs_busy, obs_hold, obs_done;
  logic [1:0]  obs_err;
  logic [10:0] obs_addr;
  logic [15:0] obs_wdata;
  logic [11:0] obs_count;

  assign obs_ready = tb_sel ? ifb.rx_ready : ifa.rx_ready;
  assign obs_we    = tb_sel ? ifb.pm_we    : ifa.pm_we;
  assign obs_busy  = tb_sel ? b_busy       : a_busy;
  assign obs_hold  = tb_sel ? b_hold       : a_hold;
  assign obs_done  = tb_sel ? b_done       : a_done;
  assign obs_err   = tb_sel ? b_err        : a_err;
  assign obs_addr  = tb_sel ? {9'd0, ifb.pm_addr} : ifa.pm_addr;
  assign obs_wdata = tb_sel ? ifb.pm_wdata : ifa.pm_wdata;
  assign obs_count = tb_sel ? {9'd0, b_count} : a_count;

  // Captured writes: {addr[15:0], word[15:0]}, one entry per cycle with pm_we
  logic [31:0] wr_got[$];
  always @(negedge clk) begin
    if (obs_we) wr_got.push_back({5'd0, obs_addr, obs_wdata});
  end

  // Stimulus byte stream and model results
  logic [7:0]  stim[$];
  logic [31:0] exp_wr[$];
  int          exp_used, exp_addr, exp_count, exp_err, exp_done;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: walks the byte stream two bytes per instruction.
  task automatic ref_model(input int addr_last);
    int i;
    logic [7:0] hi, lo;
    exp_wr.delete();
    exp_addr = 0; exp_count = 0; exp_err = 0; exp_done = 0;
    i = 0;
    while (i + 1 < stim.size() + 1) begin
      hi = stim[i]; i++;
      if (int'(hi[7:3]) > 7) begin exp_err = 1; break; end
      lo = stim[i]; i++;
      exp_wr.push_back({16'(exp_addr), hi, lo});
      exp_count++;
      if (hi[7:3] == 5'd0) begin exp_done = 1; break; end
      if (exp_addr == addr_last) begin exp_err = 2; break; end
      exp_addr++;
    end
    exp_used = i;
  endtask

  // Random program of nwords supported non-HLT words, then HLT or an illegal byte
  task automatic gen_prog(input int nwords, input bit illegal);
    logic [4:0] op;
    stim.delete();
    for (int w = 0; w < nwords; w++) begin
      op = 5'($urandom_range(7, 1));
      stim.push_back({op, 3'($urandom_range(7, 0))});
      stim.push_back(8'($urandom_range(255, 0)));
    end
    if (illegal) begin
      op = 5'($urandom_range(31, 8));
      stim.push_back({op, 3'($urandom_range(7, 0))});
    end else begin
      stim.push_back({5'd0, 3'($urandom_range(7, 0))});
      stim.push_back(8'($urandom_range(255, 0)));
    end
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 tb_start = 1'b1;
    @(posedge clk); #1 tb_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit got_it;
    got_it   = 1'b0;
    tb_valid = 1'b1;
    tb_data  = b;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (obs_ready) begin got_it = 1'b1; break; end
    end
    if (got_it) begin
      @(posedge clk); #1;
    end else begin
      check_eq("rx_ready_timeout", {31'd0, obs_ready}, 32'd1);
    end
    tb_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (!obs_busy) break;
    end
    check_eq("busy_end", {31'd0, obs_busy}, 32'd0);
  endtask

  task automatic run_session(input int addr_last, input bit extra_start);
    int gap;
    ref_model(addr_last);
    wr_got.delete();
    pulse_start();
    check_eq("start_done_clr", {31'd0, obs_done}, 32'd0);
    check_eq("start_err_clr", {30'd0, obs_err}, 32'd0);
    check_eq("start_cnt_clr", {20'd0, obs_count}, 32'd0);
    check_eq("start_busy", {31'd0, obs_busy}, 32'd1);
    if (extra_start) begin
      tb_start = 1'b1;
      @(posedge clk); #1 tb_start = 1'b0;
    end
    for (int i = 0; i < exp_used; i++) begin
      gap = $urandom_range(2, 0);
      repeat (gap) begin @(posedge clk); #1; end
      send_byte(stim[i]);
    end
    wait_idle();
    check_eq("wr_count", wr_got.size(), exp_wr.size());
    for (int i = 0; i < wr_got.size() && i < exp_wr.size(); i++)
      check_eq("wr_addr_data", wr_got[i], exp_wr[i]);
    check_eq("done", {31'd0, obs_done}, exp_done);
    check_eq("err", {30'd0, obs_err}, exp_err);
    check_eq("instr_count", {20'd0, obs_count}, exp_count);
    check_eq("pm_addr", {21'd0, obs_addr}, exp_addr);
    check_eq("cpu_hold_end", {31'd0, obs_hold}, 32'd0);
    check_eq("rx_ready_end", {31'd0, obs_ready}, 32'd0);
  endtask

  initial begin
    bit saw_ready;
    rst_n = 1'b0; tb_start = 1'b0; tb_valid = 1'b0; tb_sel = 1'b0; tb_data = 8'h00;

    // Reset state
    #12;
    check_eq("rst_busy", {31'd0, obs_busy}, 32'd0);
    check_eq("rst_ready", {31'd0, obs_ready}, 32'd0);
    check_eq("rst_we", {31'd0, obs_we}, 32'd0);
    check_eq("rst_addr", {21'd0, obs_addr}, 32'd0);
    check_eq("rst_wdata", {16'd0, obs_wdata}, 32'd0);
    check_eq("rst_count", {20'd0, obs_count}, 32'd0);
    check_eq("rst_err", {30'd0, obs_err}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 check_eq("idle_after_rst", {31'd0, obs_busy}, 32'd0);

    // Directed load: LDI 5, ADD 3, HLT
    stim.delete();
    stim.push_back(8'h18); stim.push_back(8'h05);
    stim.push_back(8'h20); stim.push_back(8'h03);
    stim.push_back(8'h00); stim.push_back(8'h00);
    run_session(2047, 1'b0);
    if (wr_got.size() == 3) begin
      check_eq("load_w0", wr_got[0], 32'h0000_1805);
      check_eq("load_w1", wr_got[1], 32'h0001_2003);
      check_eq("load_w2", wr_got[2], 32'h0002_0000);
    end else begin
      check_eq("load_nwr", wr_got.size(), 32'd3);
    end
    check_eq("load_cnt", {20'd0, obs_count}, 32'd3);

    // Bytes offered in DONE are neither consumed nor acknowledged
    wr_got.delete();
    saw_ready = 1'b0;
    tb_valid = 1'b1;
    for (int n = 0; n < 6; n++) begin
      tb_data = 8'($urandom_range(255, 0));
      @(negedge clk);
      if (obs_ready) saw_ready = 1'b1;
    end
    tb_valid = 1'b0;
    check_eq("done_ready", {31'd0, saw_ready}, 32'd0);
    check_eq("done_hold", {31'd0, obs_done}, 32'd1);
    check_eq("done_nowr", wr_got.size(), 32'd0);

    // Illegal opcode, with a start pulse ignored while in HI
    stim.delete();
    stim.push_back(8'h40);
    run_session(2047, 1'b1);
    check_eq("illegal_err", {30'd0, obs_err}, 32'd1);

    // Random sessions on the wide instance
    for (int s = 0; s < 8; s++) begin
      gen_prog($urandom_range(6, 0), ($urandom_range(3, 0) == 0));
      run_session(2047, 1'($urandom_range(1, 0)));
    end

    // Reset in the middle of a session (after the HI byte)
    pulse_start();
    send_byte(8'h3A);
    wr_got.delete();
    #2 rst_n = 1'b0;
    #1;
    check_eq("mid_rst_busy", {31'd0, obs_busy}, 32'd0);
    check_eq("mid_rst_ready", {31'd0, obs_ready}, 32'd0);
    check_eq("mid_rst_addr", {21'd0, obs_addr}, 32'd0);
    check_eq("mid_rst_wdata", {16'd0, obs_wdata}, 32'd0);
    check_eq("mid_rst_count", {20'd0, obs_count}, 32'd0);
    tb_valid = 1'b1; tb_data = 8'h55;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1 tb_valid = 1'b0;
    check_eq("mid_rst_nowr", wr_got.size(), 32'd0);
    check_eq("mid_rst_idle", {31'd0, obs_busy}, 32'd0);
    gen_prog(3, 1'b0);
    run_session(2047, 1'b0);

    // Overflow on the 2-bit instance: four non-HLT words
    tb_sel = 1'b1;
    gen_prog(4, 1'b0);
    run_session(3, 1'b0);
    check_eq("ovf_err", {30'd0, obs_err}, 32'd2);
    check_eq("ovf_addr", {21'd0, obs_addr}, 32'd3);
    check_eq("ovf_cnt", {20'd0, obs_count}, 32'd4);
    for (int s = 0; s < 5; s++) begin
      gen_prog($urandom_range(5, 0), ($urandom_range(4, 0) == 0));
      run_session(3, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
